// File: rtl/spi_csr_bridge.sv
// SPI mode-0 slave that turns 16-bit serial frames into single CSR writes or reads.
// All SPI pins are oversampled in the clk_i domain; read data returns on MISO in the next frame.
module spi_csr_bridge #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int WR_HOLD    = 6,
    parameter int RD_WAIT    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  write_en_o,
    output logic                  read_en_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam int FRAME_W   = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int BIT_CNT_W = $clog2(FRAME_W + 1);
    localparam int HOLD_MAX  = (WR_HOLD > RD_WAIT) ? WR_HOLD : RD_WAIT;
    localparam int CNT_W     = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ASSERT,
        WR_RELEASE,
        RD_ASSERT,
        RD_CAPTURE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [2:0]            sclk_q;
    logic [2:0]            cs_q;
    logic [2:0]            mosi_q;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  cs_fall;
    logic                  cs_active;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [FRAME_W-2:0]    rx_sr;
    logic [FRAME_W-1:0]    frame;
    logic                  frame_done;
    logic [FRAME_W-1:0]    tx_sr;
    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic                  capture;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] last_addr;

    // Bits [1] are the synchronised pins; bits [2] are the edge-detect history.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_i};
            cs_q   <= {cs_q[1:0], cs_n_i};
            mosi_q <= {mosi_q[1:0], mosi_i};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_active = ~cs_q[1];

    // The counter saturates at FRAME_W so trailing bits neither shift nor retrigger completion.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
        end else if (cs_fall) begin
            bit_cnt <= '0;
        end else if (sclk_rise && cs_active && (bit_cnt < BIT_CNT_W'(FRAME_W))) begin
            rx_sr   <= {rx_sr[FRAME_W-3:0], mosi_q[2]};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign frame      = {rx_sr, mosi_q[2]};
    assign frame_done = sclk_rise && cs_active && !cs_fall &&
                        (bit_cnt == BIT_CNT_W'(FRAME_W - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            tx_sr <= '0;
        end else if (cs_fall) begin
            tx_sr <= {overrun_o, last_addr, rdata_q};
        end else if (sclk_fall && cs_active) begin
            tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
        end
    end

    // Gated with the history flop so MISO only shows data once the fresh load has landed.
    assign miso_o = ~cs_q[2] & tx_sr[FRAME_W-1];

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_done) begin
                    accept     = 1'b1;
                    next_state = frame[FRAME_W-1] ? RD_ASSERT : WR_ASSERT;
                end
            end
            WR_ASSERT: begin
                if (cnt == CNT_W'(WR_HOLD - 1)) next_state = WR_RELEASE;
            end
            WR_RELEASE: begin
                if (cnt == CNT_W'(WR_HOLD - 1)) next_state = IDLE;
            end
            RD_ASSERT: begin
                if (cnt == CNT_W'(RD_WAIT - 1)) begin
                    capture    = 1'b1;
                    next_state = RD_CAPTURE;
                end
            end
            RD_CAPTURE: next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Strobes are registered from next_state so the register map never sees decode glitches.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            write_en_o   <= 1'b0;
            read_en_o    <= 1'b0;
            busy_o       <= 1'b0;
            addr_o       <= '0;
            write_data_o <= '0;
            rdata_q      <= '0;
            last_addr    <= '0;
            overrun_o    <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= ((next_state != state) || (state == IDLE)) ? '0 : cnt + 1'b1;
            write_en_o <= (next_state == WR_ASSERT);
            read_en_o  <= (next_state == RD_ASSERT);
            busy_o     <= (next_state != IDLE);
            if (accept) begin
                addr_o <= frame[FRAME_W-2 -: ADDR_WIDTH];
                if (!frame[FRAME_W-1]) write_data_o <= frame[DATA_WIDTH-1:0];
            end
            if (capture) begin
                rdata_q   <= read_data_i;
                last_addr <= addr_o;
            end
            if (frame_done && busy_o) overrun_o <= 1'b1;
        end
    end

endmodule
